// File: rtl/inst_mem_matching_bridge.sv
// Pairs instruction-memory returns with their in-order fetch addresses; flush drops in-flight returns. Optional PF: MIST1032ISA_INST_MATCHING_BRIDGE_PF_EN.
// Latency: request path combinational; matched return presented exactly 1 cycle after iMEM_VALID.
// Backpressure: oREQ_BUSY when DEPTH outstanding (drops included), memory locked or flushing; returns cannot be stalled.
module inst_mem_matching_bridge #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_N = 2
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iFLUSH,
    input  logic        iREQ_VALID,
    input  logic [31:0] iREQ_ADDR,
    output logic        oREQ_BUSY,
    output logic        oMEM_REQ,
    input  logic        iMEM_LOCK,
    output logic [31:0] oMEM_ADDR,
    input  logic        iMEM_VALID,
    input  logic        iMEM_PAGEFAULT,
    input  logic [63:0] iMEM_DATA,
    output logic        oFULL,
    output logic        oVALID,
    output logic [31:0] oADDR,
    output logic [63:0] oDATA,
    output logic        oPAGEFAULT,
    output logic        oERROR
);

    logic [31:0]        addr_mem [DEPTH];
    logic [DEPTH_N-1:0] wr_ptr;
    logic [DEPTH_N-1:0] rd_ptr;
    logic [DEPTH_N:0]   count;
    logic [DEPTH_N:0]   drop_cnt;
    logic [DEPTH_N:0]   count_nxt;
    logic [DEPTH_N:0]   drop_nxt;
    logic [DEPTH_N+1:0] outstanding;
    logic               push;
    logic               pop;
    logic               drop_hit;
    logic               orphan;
    logic               consumed;
    logic               pf_in;

`ifdef MIST1032ISA_INST_MATCHING_BRIDGE_PF_EN
    assign pf_in = iMEM_PAGEFAULT;
`else
    logic unused_pf;
    assign unused_pf = iMEM_PAGEFAULT;
    assign pf_in     = 1'b0;
`endif

    // Dropped returns still occupy memory-side slots, so they count toward full.
    assign outstanding = {1'b0, count} + {1'b0, drop_cnt};
    assign oFULL       = (outstanding == (DEPTH_N+2)'(DEPTH));
    assign oREQ_BUSY   = oFULL | iMEM_LOCK | iFLUSH;
    assign oMEM_REQ    = iREQ_VALID & ~oREQ_BUSY;
    assign oMEM_ADDR   = iREQ_ADDR;

    assign push     = oMEM_REQ;
    assign drop_hit = iMEM_VALID && (drop_cnt != '0);
    assign pop      = iMEM_VALID && (drop_cnt == '0) && (count != '0);
    assign orphan   = iMEM_VALID && (drop_cnt == '0) && (count == '0);
    assign consumed = drop_hit | pop;

    always_comb begin
        count_nxt = count;
        drop_nxt  = drop_cnt;
        if (iFLUSH) begin
            // Everything still queued becomes a pending drop, minus a return absorbed this cycle.
            count_nxt = '0;
            drop_nxt  = drop_cnt + count - {{DEPTH_N{1'b0}}, consumed};
        end else begin
            count_nxt = count + {{DEPTH_N{1'b0}}, push} - {{DEPTH_N{1'b0}}, pop};
            drop_nxt  = drop_cnt - {{DEPTH_N{1'b0}}, drop_hit};
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
            end
        end else begin
            count    <= count_nxt;
            drop_cnt <= drop_nxt;
            if (push) begin
                addr_mem[wr_ptr] <= iREQ_ADDR;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (iFLUSH) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            oVALID     <= 1'b0;
            oADDR      <= '0;
            oDATA      <= '0;
            oPAGEFAULT <= 1'b0;
            oERROR     <= 1'b0;
        end else begin
            oVALID <= pop & ~iFLUSH;
            if (pop && !iFLUSH) begin
                oADDR      <= addr_mem[rd_ptr];
                oDATA      <= iMEM_DATA;
                oPAGEFAULT <= pf_in;
            end
            if (orphan) begin
                oERROR <= 1'b1;
            end
        end
    end

endmodule

// File: doc/inst_mem_matching_bridge.md
Name: inst_mem_matching_bridge

Overview:
- Sits between the instruction fetch request path and instruction memory.
- Forwards fetch requests and records each accepted request address in an in-order tag FIFO.
- Pairs every memory return with its originating address and presents the pair to the fetch/L1 fill side one cycle later.
- On a pipeline flush, discards returns still in flight, so stale data never reaches fetch.

Parameters:
- DEPTH, 4, maximum number of outstanding requests (power of two).
- DEPTH_N, 2, log2(DEPTH); pointer width.

Ports:
- iCLOCK  in  1  core clock
- inRESET  in  1  asynchronous active-low reset
- iFLUSH  in  1  core flush; one-cycle pulse
- iREQ_VALID  in  1  fetch request
- iREQ_ADDR  in  32  fetch address
- oREQ_BUSY  out  1  request not accepted this cycle
- oMEM_REQ  out  1  request to instruction memory
- iMEM_LOCK  in  1  memory cannot accept a request
- oMEM_ADDR  out  32  address to memory
- iMEM_VALID  in  1  memory return valid; cannot be stalled
- iMEM_PAGEFAULT  in  1  return carries a page fault
- iMEM_DATA  in  64  return data
- oFULL  out  1  DEPTH requests outstanding, drops included
- oVALID  out  1  matched return valid
- oADDR  out  32  address of the matched return
- oDATA  out  64  matched data
- oPAGEFAULT  out  1  matched page fault
- oERROR  out  1  sticky: return arrived with nothing outstanding

Behaviour:
- Clock and reset: single clock iCLOCK; reset inRESET is asynchronous, active-low.
- Reset values: all outputs 0. FIFO pointers, occupancy count and drop counter are 0.
- Outstanding count: outstanding = FIFO occupancy + drop counter.
  - oFULL = (outstanding == DEPTH).
  - oFULL is combinational from registered state.
- Request path (combinational):
  - oMEM_REQ = iREQ_VALID && !oFULL && !iMEM_LOCK && !iFLUSH.
  - oMEM_ADDR = iREQ_ADDR.
  - oREQ_BUSY = oFULL || iMEM_LOCK || iFLUSH.
- Push: when oMEM_REQ is 1, write iREQ_ADDR at the write pointer and increment it (wraps modulo DEPTH).
- Return with drops pending: if iMEM_VALID and drop counter != 0, decrement the drop counter. The return is discarded and oVALID stays 0 next cycle.
- Return with drops clear: if iMEM_VALID, drop counter == 0 and FIFO not empty:
  - pop the head entry;
  - next cycle oVALID=1, oADDR=head address, oDATA=iMEM_DATA, oPAGEFAULT=iMEM_PAGEFAULT.
  - Latency is exactly 1 cycle.
  - oVALID is a one-cycle pulse. Output data holds its last value when oVALID=0.
- Orphan return: if iMEM_VALID, drop counter == 0 and FIFO empty:
  - set oERROR;
  - oVALID stays 0;
  - oERROR clears only on inRESET.
- Simultaneous push and pop: both happen; occupancy unchanged. Full plus a pop in the same cycle still blocks the push, because oFULL uses registered state.
- Flush (iFLUSH=1):
  - Empty the FIFO: read pointer = write pointer, occupancy 0.
  - Drop counter loads (current drop counter + FIFO occupancy − 1 if a return is consumed this cycle, else + 0).
  - The oVALID for a return consumed in the flush cycle is suppressed (forced 0).
  - No push occurs in the flush cycle.
- Flush with returns pending: a flush while drops are still pending adds to the existing drop count. The drop counter never exceeds DEPTH; its width is DEPTH_N+1.
- Wrap-around: pointers are DEPTH_N bits; occupancy is DEPTH_N+1 bits. Full occurs when occupancy == DEPTH.
- Reset mid-operation: asynchronously clears everything. Returns still in flight in memory at reset are the system's responsibility; memory is reset by the same inRESET.

Optional Feature:
- Macro: MIST1032ISA_INST_MATCHING_BRIDGE_PF_EN.
- Defined: oPAGEFAULT carries iMEM_PAGEFAULT as specified.
- Undefined: iMEM_PAGEFAULT is ignored and oPAGEFAULT is tied to 0. All other behaviour is unchanged.

Test Plan:
- Single fetch: push 0x0000_1000; return data 0xDEAD_BEEF_0123_4567 three cycles later -> one cycle after the return, oVALID=1, oADDR=0x0000_1000, oDATA=0xDEAD_BEEF_0123_4567.
- Fill and order: issue 4 requests 0x100, 0x108, 0x110, 0x118 with no returns -> oFULL=1, a 5th request gives oREQ_BUSY=1 and oMEM_REQ=0. Then 4 returns -> oADDR sequence 0x100, 0x108, 0x110, 0x118 and oFULL deasserts after the first return.
- Flush drop: issue 3 requests, pulse iFLUSH, then 3 returns, then a new request 0x2000 and its return -> the first 3 returns produce no oVALID; the next oVALID has oADDR=0x2000.
- Flush coinciding with a return: 2 outstanding, iFLUSH and iMEM_VALID in the same cycle -> no oVALID next cycle, drop counter = 1, the next return is dropped.
- Lock and orphan: iMEM_LOCK=1 with iREQ_VALID=1 -> oMEM_REQ=0, no push. An iMEM_VALID with nothing outstanding -> oERROR=1 and it stays set until inRESET.
- PF macro: return with iMEM_PAGEFAULT=1 -> oPAGEFAULT=1 when the macro is defined, 0 when it is undefined.
